// File: rtl/writeback_fifo_mp.sv
// writeback_fifo_mp: NUM_IN-wide compacting writeback queue draining NUM_OUT oldest entries per cycle to RF lanes.
// Latency: 2 edges input to output; 1 edge into an empty queue when WB_FIFO_BYPASS_EN is defined.
// Backpressure: in_ready_o low when fewer than NUM_IN slots remain; writes then are dropped and set sticky overflow_o.
module writeback_fifo_mp #(
  parameter int NUM_IN   = 4,
  parameter int NUM_OUT  = 2,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int STATUS_W = 2
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [NUM_IN-1:0]           in_valid_i,
  input  logic [NUM_IN*ADDR_W-1:0]    in_addr_i,
  input  logic [NUM_IN*DATA_W-1:0]    in_data_i,
  input  logic [NUM_IN*STATUS_W-1:0]  in_status_i,
  output logic                        in_ready_o,
  output logic [NUM_OUT-1:0]          out_enable_o,
  output logic [NUM_OUT*ADDR_W-1:0]   out_addr_o,
  output logic [NUM_OUT*DATA_W-1:0]   out_data_o,
  output logic [NUM_OUT*STATUS_W-1:0] out_status_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LANES     = CNT_W'(NUM_OUT);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - NUM_IN);

  // Storage payload is never reset; head/tail/count define what is live.
  logic [ADDR_W-1:0]   memAddr   [DEPTH];
  logic [DATA_W-1:0]   memData   [DEPTH];
  logic [STATUS_W-1:0] memStatus [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic              inReady;
  logic [NUM_IN-1:0] accept;
  logic [CNT_W-1:0]  slot [NUM_IN];
  logic [CNT_W-1:0]  pushCnt;
  logic [CNT_W-1:0]  bypassCnt;
  logic [CNT_W-1:0]  storeCnt;
  logic [CNT_W-1:0]  popCnt;

  logic [ADDR_W-1:0]   cmpAddr   [NUM_IN];
  logic [DATA_W-1:0]   cmpData   [NUM_IN];
  logic [STATUS_W-1:0] cmpStatus [NUM_IN];

  logic [NUM_OUT-1:0]          nextEnable;
  logic [NUM_OUT*ADDR_W-1:0]   nextAddr;
  logic [NUM_OUT*DATA_W-1:0]   nextData;
  logic [NUM_OUT*STATUS_W-1:0] nextStatus;

  // Ready looks only at registered occupancy, so no path from in_valid_i.
  assign inReady = (count <= READY_MAX);
  assign accept  = in_valid_i & {NUM_IN{inReady}};

  // Position of each accepted channel in this cycle's gap-free group (ascending channel index)
  always_comb begin
    pushCnt = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      slot[k] = pushCnt;
      pushCnt = pushCnt + CNT_W'(accept[k]);
    end
  end

  // Gather accepted channels into compacted slots 0..pushCnt-1
  always_comb begin
    for (int j = 0; j < NUM_IN; j++) begin
      cmpAddr[j]   = '0;
      cmpData[j]   = '0;
      cmpStatus[j] = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        if (accept[k] && slot[k] == CNT_W'(j)) begin
          cmpAddr[j]   = in_addr_i[k*ADDR_W +: ADDR_W];
          cmpData[j]   = in_data_i[k*DATA_W +: DATA_W];
          cmpStatus[j] = in_status_i[k*STATUS_W +: STATUS_W];
        end
      end
    end
  end

  // Split this cycle's traffic into drained, bypassed and stored entry counts
  always_comb begin
    popCnt = (count > LANES) ? LANES : count;
`ifdef WB_FIFO_BYPASS_EN
    // Only an empty queue may bypass; otherwise older entries would be overtaken.
    bypassCnt = (count == '0) ? ((pushCnt > LANES) ? LANES : pushCnt) : '0;
`else
    bypassCnt = '0;
`endif
    storeCnt = pushCnt - bypassCnt;
  end

  // Select next lane contents: bypassed entries first, else oldest stored entries
  always_comb begin
    nextEnable = '0;
    nextAddr   = '0;
    nextData   = '0;
    nextStatus = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (CNT_W'(j) < bypassCnt) begin
        nextEnable[j]                        = 1'b1;
        nextAddr[j*ADDR_W +: ADDR_W]         = cmpAddr[j];
        nextData[j*DATA_W +: DATA_W]         = cmpData[j];
        nextStatus[j*STATUS_W +: STATUS_W]   = cmpStatus[j];
      end else if (CNT_W'(j) < popCnt) begin
        nextEnable[j]                        = 1'b1;
        nextAddr[j*ADDR_W +: ADDR_W]         = memAddr[head + PTR_W'(j)];
        nextData[j*DATA_W +: DATA_W]         = memData[head + PTR_W'(j)];
        nextStatus[j*STATUS_W +: STATUS_W]   = memStatus[head + PTR_W'(j)];
      end
    end
  end

  // Write non-bypassed compacted entries at tail onward, wrapping modulo DEPTH
  always_ff @(posedge clock_i) begin
    for (int j = 0; j < NUM_IN; j++) begin
      if (CNT_W'(j) >= bypassCnt && CNT_W'(j) < pushCnt) begin
        memAddr[tail + PTR_W'(j) - bypassCnt[PTR_W-1:0]]   <= cmpAddr[j];
        memData[tail + PTR_W'(j) - bypassCnt[PTR_W-1:0]]   <= cmpData[j];
        memStatus[tail + PTR_W'(j) - bypassCnt[PTR_W-1:0]] <= cmpStatus[j];
      end
    end
  end

  // Pointers, occupancy, sticky overflow and registered output lanes
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      out_enable_o <= '0;
      out_addr_o   <= '0;
      out_data_o   <= '0;
      out_status_o <= '0;
    end else begin
      head         <= head + popCnt[PTR_W-1:0];
      tail         <= tail + storeCnt[PTR_W-1:0];
      count        <= count + storeCnt - popCnt;
      if (|in_valid_i && !inReady) begin
        overflow <= 1'b1;
      end
      out_enable_o <= nextEnable;
      out_addr_o   <= nextAddr;
      out_data_o   <= nextData;
      out_status_o <= nextStatus;
    end
  end

  assign in_ready_o = inReady;
  assign count_o    = count;
  assign overflow_o = overflow;

endmodule
